// File: rtl/mlp_mac_pipe_if.sv
// Beat/result bundle for mlp_mac_pipe: per-beat operands and markers in, rescaled lane results out.
// The master drives beats, and the slave (the MAC engine) returns the results.
interface mlp_mac_pipe_if #(
    parameter int LANES     = 4,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 16
);
    logic                       in_valid;
    logic                       in_start;
    logic                       in_last;
    logic [LANES*A_WIDTH-1:0]   a;
    logic [LANES*B_WIDTH-1:0]   b;
    logic [LANES*OUT_WIDTH-1:0] out_data;
    logic                       out_valid;
    logic [LANES-1:0]           out_sat;
    logic                       busy;

    modport master (
        output in_valid, in_start, in_last, a, b,
        input  out_data, out_valid, out_sat, busy
    );

    modport slave (
        input  in_valid, in_start, in_last, a, b,
        output out_data, out_valid, out_sat, busy
    );
endinterface

// File: rtl/mlp_mac_pipe.sv
// Multi-lane pipelined signed MAC: product register, accumulate, then round/rescale/saturate.
// Define MLP_MAC_RELU_EN to fuse a ReLU into the output stage (negatives become 0 and are not flagged).
module mlp_mac_pipe #(
    parameter int LANES     = 4,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = 40,
    parameter int FRAC_BITS = 8,
    parameter int OUT_WIDTH = 16
) (
    input logic         clk,
    input logic         rst_n,
    mlp_mac_pipe_if.slave bus
);

    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int RW = ACC_WIDTH + 1;

    // One extra bit keeps the round-half-up add from wrapping at the accumulator extremes.
    localparam logic [RW-1:0]        RND_U   = ({{(RW-1){1'b0}}, 1'b1} << FRAC_BITS) >> 1;
    localparam logic signed [RW-1:0] OUT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] OUT_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic                        s1_valid;
    logic                        s1_start;
    logic                        s1_last;
    logic                        s2_fire;
    logic signed [PW-1:0]        s1_prod [LANES];
    logic signed [ACC_WIDTH-1:0] acc     [LANES];
    logic [LANES*OUT_WIDTH-1:0]  next_data;
    logic [LANES-1:0]            next_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_start <= 1'b0;
            s1_last  <= 1'b0;
            s2_fire  <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_start <= bus.in_valid & bus.in_start;
            s1_last  <= bus.in_valid & bus.in_last;
            s2_fire  <= s1_valid & s1_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
                acc[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.in_valid) begin
                    s1_prod[i] <= PW'($signed(bus.a[i*A_WIDTH +: A_WIDTH])) *
                                  PW'($signed(bus.b[i*B_WIDTH +: B_WIDTH]));
                end
                if (s1_valid) begin
                    acc[i] <= s1_start ? ACC_WIDTH'(s1_prod[i])
                                       : acc[i] + ACC_WIDTH'(s1_prod[i]);
                end
            end
        end
    end

    always_comb begin
        logic signed [RW-1:0] rnd_sum;
        logic signed [RW-1:0] rnd_q;
        next_data = '0;
        next_sat  = '0;
        for (int i = 0; i < LANES; i++) begin
            rnd_sum = RW'(acc[i]) + $signed(RND_U);
            rnd_q   = rnd_sum >>> FRAC_BITS;
`ifdef MLP_MAC_RELU_EN
            if (rnd_q[RW-1]) begin
                rnd_q = '0;
            end
`endif
            if (rnd_q > OUT_MAX) begin
                next_data[i*OUT_WIDTH +: OUT_WIDTH] = OUT_MAX[OUT_WIDTH-1:0];
                next_sat[i] = 1'b1;
            end else if (rnd_q < OUT_MIN) begin
                next_data[i*OUT_WIDTH +: OUT_WIDTH] = OUT_MIN[OUT_WIDTH-1:0];
                next_sat[i] = 1'b1;
            end else begin
                next_data[i*OUT_WIDTH +: OUT_WIDTH] = rnd_q[OUT_WIDTH-1:0];
            end
        end
    end

    // Results are held between vectors, so only the pulse itself goes back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= '0;
        end else begin
            bus.out_valid <= s2_fire;
            if (s2_fire) begin
                bus.out_data <= next_data;
                bus.out_sat  <= next_sat;
            end
        end
    end

    assign bus.busy = s1_valid | s2_fire;

endmodule

// File: tb/tb_mlp_mac_pipe.sv
// Self-checking bench for mlp_mac_pipe: directed vector table, corner sequences and a random run
// checked every cycle against an arithmetic dot-product model (honours MLP_MAC_RELU_EN).
module tb_mlp_mac_pipe;

    localparam int LANES = 4;
    localparam int AW    = 16;
    localparam int BW    = 16;
    localparam int ACCW  = 40;
    localparam int FRAC  = 8;
    localparam int OW    = 16;
    localparam longint RND = (longint'(1) << FRAC) >> 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expData;
        logic        expSat;
    } vecRow;

    typedef struct {
        int          due;
        logic [63:0] data;
        logic [3:0]  sat;
    } expRec;

    logic clk;
    logic rst_n;

    mlp_mac_pipe_if #(.LANES(LANES), .A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus ();

    mlp_mac_pipe #(
        .LANES(LANES), .A_WIDTH(AW), .B_WIDTH(BW),
        .ACC_WIDTH(ACCW), .FRAC_BITS(FRAC), .OUT_WIDTH(OW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checkCount = 0;
    int          passCount  = 0;
    int          edgeCount  = 0;
    longint      modelAcc [LANES];
    expRec       expQ [$];
    logic [63:0] heldData;
    logic [3:0]  heldSat;
    bit          validHist [int];
    bit          lastHist  [int];

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edgeCount, act, exp);
        end else begin
            passCount++;
        end
    endtask

    function automatic longint wrapAcc(input longint v);
        longint r;
        r = v <<< (64 - ACCW);
        return r >>> (64 - ACCW);
    endfunction

    function automatic void rescaleModel(input longint accv, output logic [15:0] d, output bit s);
        longint r;
        r = (accv + RND) >>> FRAC;
`ifdef MLP_MAC_RELU_EN
        if (r < 0) r = 0;
`endif
        s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
        d = r[15:0];
    endfunction

    function automatic bit histV(input int n);
        return validHist.exists(n) ? validHist[n] : 1'b0;
    endfunction

    function automatic bit histL(input int n);
        return lastHist.exists(n) ? lastHist[n] : 1'b0;
    endfunction

    function automatic logic [63:0] bcast(input logic [15:0] v);
        return {4{v}};
    endfunction

    task automatic checkOutput();
        bit expValid;
        bit expBusy;
        expValid = (expQ.size() > 0) && (expQ[0].due == edgeCount);
        checkValue("out_valid", {63'b0, bus.out_valid}, {63'b0, expValid});
        if (expValid) begin
            heldData = expQ[0].data;
            heldSat  = expQ[0].sat;
            void'(expQ.pop_front());
        end
        checkValue("out_data", bus.out_data, heldData);
        checkValue("out_sat", {60'b0, bus.out_sat}, {60'b0, heldSat});
        expBusy = histV(edgeCount) | (histV(edgeCount - 1) & histL(edgeCount - 1));
        checkValue("busy", {63'b0, bus.busy}, {63'b0, expBusy});
    endtask

    task automatic tick();
        @(posedge clk);
        edgeCount++;
        #1;
        checkOutput();
    endtask

    // The model sees each beat when it is driven; it is sampled on the next edge.
    task automatic applyStimulus(input bit v, input bit s, input bit l,
                                 input logic [63:0] av, input logic [63:0] bv);
        int          e;
        longint      p;
        expRec       rec;
        logic [15:0] d;
        bit          st;
        bus.in_valid = v;
        bus.in_start = s;
        bus.in_last  = l;
        bus.a        = av;
        bus.b        = bv;
        if (v) begin
            e = edgeCount + 1;
            validHist[e] = 1'b1;
            lastHist[e]  = l;
            for (int i = 0; i < LANES; i++) begin
                p = longint'($signed(av[i*16 +: 16])) * longint'($signed(bv[i*16 +: 16]));
                modelAcc[i] = s ? p : wrapAcc(modelAcc[i] + p);
            end
            if (l) begin
                rec.due  = e + 2;
                rec.data = '0;
                rec.sat  = '0;
                for (int i = 0; i < LANES; i++) begin
                    rescaleModel(modelAcc[i], d, st);
                    rec.data[i*16 +: 16] = d;
                    rec.sat[i] = st;
                end
                expQ.push_back(rec);
            end
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic modelReset();
        expQ.delete();
        validHist.delete();
        lastHist.delete();
        heldData = '0;
        heldSat  = '0;
        for (int i = 0; i < LANES; i++) modelAcc[i] = 0;
    endtask

    function automatic logic [15:0] randOperand();
        int mode;
        mode = int'($urandom_range(0, 3));
        case (mode)
            0:       return 16'($signed(int'($urandom_range(0, 600)) - 300));
            1:       return ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    vecRow table_v [6];

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;

        table_v[0] = '{16'd1,    16'd128, 16'h0001, 1'b0};
        table_v[1] = '{16'd1,    16'd127, 16'h0000, 1'b0};
        table_v[2] = '{16'hFFFF, 16'd128, 16'h0000, 1'b0};
        table_v[3] = '{16'd256,  16'd256, 16'h0100, 1'b0};
`ifdef MLP_MAC_RELU_EN
        table_v[4] = '{16'hFFFF, 16'd129, 16'h0000, 1'b0};
        table_v[5] = '{16'hFF00, 16'd512, 16'h0000, 1'b0};
`else
        table_v[4] = '{16'hFFFF, 16'd129, 16'hFFFF, 1'b0};
        table_v[5] = '{16'hFF00, 16'd512, 16'hFE00, 1'b0};
`endif

        modelReset();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        bus.in_last  = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        #2 rst_n = 1'b0;
        #1;
        checkValue("rst_valid", {63'b0, bus.out_valid}, 64'h0);
        checkValue("rst_data", bus.out_data, 64'h0);
        checkValue("rst_sat", {60'b0, bus.out_sat}, 64'h0);
        checkValue("rst_busy", {63'b0, bus.busy}, 64'h0);
        tick();
        tick();
        #2 rst_n = 1'b1;

        for (int r = 0; r < 6; r++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, bcast(table_v[r].a), bcast(table_v[r].b));
            idle(2);
            checkValue("tbl_valid", {63'b0, bus.out_valid}, 64'h1);
            checkValue("tbl_data", bus.out_data, bcast(table_v[r].expData));
            checkValue("tbl_sat", {60'b0, bus.out_sat}, {60'b0, {4{table_v[r].expSat}}});
        end

        // Two-beat lane-0 vector: 256*512 + 256*256 = 196608 -> 768.
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd256, 64'd512);
        applyStimulus(1'b1, 1'b0, 1'b1, 64'd256, 64'd256);
        idle(1);
        checkValue("ex1_early", {63'b0, bus.out_valid}, 64'h0);
        idle(1);
        checkValue("ex1_valid", {63'b0, bus.out_valid}, 64'h1);
        checkValue("ex1_data", bus.out_data, 64'h0000_0000_0000_0300);

        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, k == 0, k == 3, bcast(16'h7FFF), bcast(16'h7FFF));
        idle(2);
        checkValue("satpos_data", bus.out_data, bcast(16'h7FFF));
        checkValue("satpos_sat", {60'b0, bus.out_sat}, 64'hF);

        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, k == 0, k == 3, bcast(16'h7FFF), bcast(16'h8000));
        idle(2);
`ifdef MLP_MAC_RELU_EN
        checkValue("satneg_data", bus.out_data, 64'h0);
        checkValue("satneg_sat", {60'b0, bus.out_sat}, 64'h0);
`else
        checkValue("satneg_data", bus.out_data, bcast(16'h8000));
        checkValue("satneg_sat", {60'b0, bus.out_sat}, 64'hF);
`endif

        // Back-to-back: A = 3*256 -> 3, B starts right after A's last, with a bubble -> 8.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, k == 0, k == 2, bcast(16'd16), bcast(16'd16));
        applyStimulus(1'b1, 1'b1, 1'b0, bcast(16'd32), bcast(16'd32));
        idle(1);
        checkValue("b2b_a", bus.out_data, bcast(16'd3));
        applyStimulus(1'b1, 1'b0, 1'b1, bcast(16'd32), bcast(16'd32));
        idle(2);
        checkValue("b2b_b", bus.out_data, bcast(16'd8));

        // Restart mid-vector: only the second vector may produce a result.
        applyStimulus(1'b1, 1'b1, 1'b0, bcast(16'd1000), bcast(16'd1000));
        applyStimulus(1'b1, 1'b0, 1'b0, bcast(16'd1000), bcast(16'd1000));
        applyStimulus(1'b1, 1'b1, 1'b1, bcast(16'd512), bcast(16'd2));
        idle(3);

        // Reset right after a last beat: the pending result must vanish.
        applyStimulus(1'b1, 1'b1, 1'b0, bcast(16'd700), bcast(16'd700));
        applyStimulus(1'b1, 1'b0, 1'b1, bcast(16'd700), bcast(16'd700));
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkValue("mid_rst_valid", {63'b0, bus.out_valid}, 64'h0);
        checkValue("mid_rst_data", bus.out_data, 64'h0);
        checkValue("mid_rst_busy", {63'b0, bus.busy}, 64'h0);
        idle(2);
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, bcast(16'd256), bcast(16'd256));
        idle(2);
        checkValue("post_rst_data", bus.out_data, bcast(16'h0100));
        idle(2);

        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < LANES; i++) begin
                ra[i*16 +: 16] = randOperand();
                rb[i*16 +: 16] = randOperand();
            end
            applyStimulus($urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 4) == 0, ra, rb);
        end
        idle(4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
